// File: rtl/tank_shell.sv
// Single-shell projectile stage for one player tank: fires on a key press edge,
// flies one step per frame, and ends on enemy contact, barrier or playfield edge.
module tank_shell #(
  parameter logic [7:0] FIRE_KEY        = 8'd44,
  parameter logic [9:0] SHELL_STEP      = 10'd4,
  parameter logic [9:0] SHELL_SIZE      = 10'd2,
  parameter logic [7:0] COOLDOWN_FRAMES = 8'd30,
  parameter logic [9:0] X_MIN           = 10'd0,
  parameter logic [9:0] X_MAX           = 10'd639,
  parameter logic [9:0] Y_MIN           = 10'd0,
  parameter logic [9:0] Y_MAX           = 10'd479
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic [9:0] TankX,
  input  logic [9:0] TankY,
  input  logic [9:0] TankS,
  input  logic [1:0] direction,
  input  logic [9:0] EnemyX,
  input  logic [9:0] EnemyY,
  input  logic [9:0] EnemyS,
  input  logic       barrier_hit,
  output logic [9:0] ShellX,
  output logic [9:0] ShellY,
  output logic [9:0] ShellS,
  output logic       shell_active,
  output logic       enemy_hit
);

  // Wide enough that TankX + TankS + SHELL_SIZE + 1 never wraps and underflow stays negative.
  localparam int unsigned CW = 13;
  localparam logic [7:0] CD_LOAD = (COOLDOWN_FRAMES == 8'd0) ? 8'd1 : COOLDOWN_FRAMES;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } state_t;

  state_t              state;
  logic [1:0]          dir;
  logic [7:0]          cd_cnt;
  logic                key_prev;

  logic                key_match;
  logic                fire_edge;
  logic signed [CW-1:0] off;
  logic signed [CW-1:0] spawn_x;
  logic signed [CW-1:0] spawn_y;
  logic signed [CW-1:0] next_x;
  logic signed [CW-1:0] next_y;
  logic signed [CW-1:0] dx;
  logic signed [CW-1:0] dy;
  logic signed [CW-1:0] reach;
  logic                spawn_ok;
  logic                next_ok;
  logic                overlap;

  function automatic logic signed [CW-1:0] ext(input logic [9:0] v);
    return $signed({3'b000, v});
  endfunction

  function automatic logic signed [CW-1:0] iabs(input logic signed [CW-1:0] v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic logic in_range(input logic signed [CW-1:0] v,
                                    input logic [9:0] lo,
                                    input logic [9:0] hi);
    return (v >= ext(lo)) && (v <= ext(hi));
  endfunction

  assign ShellS = SHELL_SIZE;

  // Spawn point, next flight position and enemy overlap, all in wide signed arithmetic.
  always_comb begin
    key_match = (keycode == FIRE_KEY);
    fire_edge = key_match & ~key_prev;

    off     = ext(TankS) + ext(SHELL_SIZE) + 13'sd1;
    spawn_x = ext(TankX);
    spawn_y = ext(TankY);
    case (direction)
      2'b00:   spawn_x = ext(TankX) - off;
      2'b01:   spawn_x = ext(TankX) + off;
      2'b10:   spawn_y = ext(TankY) + off;
      default: spawn_y = ext(TankY) - off;
    endcase
    spawn_ok = in_range(spawn_x, X_MIN, X_MAX) && in_range(spawn_y, Y_MIN, Y_MAX);

    next_x = ext(ShellX);
    next_y = ext(ShellY);
    case (dir)
      2'b00:   next_x = ext(ShellX) - ext(SHELL_STEP);
      2'b01:   next_x = ext(ShellX) + ext(SHELL_STEP);
      2'b10:   next_y = ext(ShellY) + ext(SHELL_STEP);
      default: next_y = ext(ShellY) - ext(SHELL_STEP);
    endcase
    next_ok = in_range(next_x, X_MIN, X_MAX) && in_range(next_y, Y_MIN, Y_MAX);

    dx      = iabs(ext(ShellX) - ext(EnemyX));
    dy      = iabs(ext(ShellY) - ext(EnemyY));
    reach   = ext(EnemyS) + ext(SHELL_SIZE);
    overlap = (dx <= reach) && (dy <= reach);
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      state        <= IDLE;
      ShellX       <= 10'd0;
      ShellY       <= 10'd0;
      shell_active <= 1'b0;
      enemy_hit    <= 1'b0;
      cd_cnt       <= 8'd0;
      dir          <= 2'b00;
      // Tracking the key during reset keeps a key held through reset from firing on release of reset.
      key_prev     <= key_match;
    end else begin
      key_prev  <= key_match;
      enemy_hit <= 1'b0;
      case (state)
        IDLE: begin
          if (fire_edge) begin
            dir <= direction;
            if (spawn_ok) begin
              ShellX       <= spawn_x[9:0];
              ShellY       <= spawn_y[9:0];
              shell_active <= 1'b1;
              state        <= FLYING;
            end else begin
              cd_cnt <= CD_LOAD;
              state  <= COOLDOWN;
            end
          end
        end
        FLYING: begin
          if (overlap || barrier_hit || !next_ok) begin
            enemy_hit    <= overlap;
            shell_active <= 1'b0;
            cd_cnt       <= CD_LOAD;
            state        <= COOLDOWN;
          end else begin
            ShellX <= next_x[9:0];
            ShellY <= next_y[9:0];
          end
        end
        COOLDOWN: begin
          cd_cnt <= cd_cnt - 8'd1;
          if (cd_cnt <= 8'd1) begin
            state <= IDLE;
          end
        end
        default: begin
          shell_active <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule
